// File: rtl/multu_hilo_unit.sv
// multu_hilo_unit
//
// Multi-cycle unsigned WIDTH x WIDTH shift-add multiplier with the HI/LO
// registers of the MIPS execute stage. A MULTU is accepted from IDLE and then
// iterates WIDTH times. HI/LO are written together on the last iteration, and
// done pulses for one cycle afterwards. MFHI/MFLO read HI/LO combinationally.
// A stall is requested only while a multiply is in flight and a dependent
// HI/LO access or another MULTU is present in EX.
//
// Ports:
//   clk      system clock, rising-edge
//   rst      asynchronous active-high reset
//   start    MULTU in EX (level, sampled every edge; ignored while busy)
//   src_a    multiplicand (rs)
//   src_b    multiplier (rt)
//   rd_hi    MFHI in EX (priority over rd_lo)
//   rd_lo    MFLO in EX
//   rd_data  HI if rd_hi, else LO (combinational)
//   busy     multiply in progress
//   stall    pipeline hold request
//   done     one-cycle pulse after HI/LO were written
//   hi, lo   architectural HI/LO registers

module multu_hilo_unit #(
  parameter int unsigned WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] src_a,
  input  logic [WIDTH-1:0] src_b,
  input  logic             rd_hi,
  input  logic             rd_lo,
  output logic [WIDTH-1:0] rd_data,
  output logic             busy,
  output logic             stall,
  output logic             done,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo
);

  localparam int unsigned CntW = $clog2(WIDTH) + 1;
  localparam int unsigned AccW = 2 * WIDTH + 1;

  typedef enum logic {
    StIdle,
    StRun
  } state_e;

  state_e state_q, state_d;

  logic [WIDTH-1:0] mcand_q, mcand_d;
  // acc[2W] is the carry out of the partial-product add, acc[W-1:0] holds the
  // remaining multiplier bits, which shift out as product bits shift in.
  logic [AccW-1:0]  acc_q, acc_d;
  logic [CntW-1:0]  count_q, count_d;
  logic [WIDTH-1:0] hi_q, hi_d;
  logic [WIDTH-1:0] lo_q, lo_d;
  logic             done_q, done_d;

  logic [WIDTH:0]   sum;
  logic [AccW-1:0]  acc_step;
  logic             last_iter;

  // One shift-add iteration: conditionally add the multiplicand into the
  // upper half (keeping the carry), then shift the whole accumulator right.
  always_comb begin
    sum      = {1'b0, acc_q[2*WIDTH-1:WIDTH]};
    if (acc_q[0]) begin
      sum = {1'b0, acc_q[2*WIDTH-1:WIDTH]} + {1'b0, mcand_q};
    end
    acc_step  = {1'b0, sum, acc_q[WIDTH-1:1]};
    last_iter = (count_q == CntW'(WIDTH - 1));
  end

  always_comb begin
    state_d = state_q;
    mcand_d = mcand_q;
    acc_d   = acc_q;
    count_d = count_q;
    hi_d    = hi_q;
    lo_d    = lo_q;
    done_d  = 1'b0;

    unique case (state_q)
      StIdle: begin
        if (start) begin
          mcand_d = src_a;
          acc_d   = {{(WIDTH + 1){1'b0}}, src_b};
          count_d = '0;
          state_d = StRun;
        end
      end
      StRun: begin
        acc_d   = acc_step;
        count_d = count_q + CntW'(1);
        if (last_iter) begin
          // The product commits on the same edge as the final iteration.
          hi_d    = acc_step[2*WIDTH-1:WIDTH];
          lo_d    = acc_step[WIDTH-1:0];
          done_d  = 1'b1;
          state_d = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= StIdle;
      mcand_q <= '0;
      acc_q   <= '0;
      count_q <= '0;
      hi_q    <= '0;
      lo_q    <= '0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      mcand_q <= mcand_d;
      acc_q   <= acc_d;
      count_q <= count_d;
      hi_q    <= hi_d;
      lo_q    <= lo_d;
      done_q  <= done_d;
    end
  end

  assign busy    = (state_q == StRun);
  // A MULTU arriving during RUN is held by the pipeline and accepted on the
  // first IDLE edge, which is the done cycle.
  assign stall   = busy & (start | rd_hi | rd_lo);
  assign rd_data = rd_hi ? hi_q : lo_q;
  assign done    = done_q;
  assign hi      = hi_q;
  assign lo      = lo_q;

endmodule

// File: tb/tb_multu_hilo_unit.sv
module tb_multu_hilo_unit;

  logic        clk;
  logic        rst;
  logic        start;
  logic [31:0] src_a;
  logic [31:0] src_b;
  logic        rd_hi;
  logic        rd_lo;
  logic [31:0] rd_data;
  logic        busy;
  logic        stall;
  logic        done;
  logic [31:0] hi;
  logic [31:0] lo;

  int n_cmp = 0;
  int n_err = 0;

  multu_hilo_unit #(.WIDTH(32)) dut (
    .clk     (clk),
    .rst     (rst),
    .start   (start),
    .src_a   (src_a),
    .src_b   (src_b),
    .rd_hi   (rd_hi),
    .rd_lo   (rd_lo),
    .rd_data (rd_data),
    .busy    (busy),
    .stall   (stall),
    .done    (done),
    .hi      (hi),
    .lo      (lo)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Counts negedges until done is seen (bounded) and how many of them had busy=1.
  task automatic wait_done(output int cyc, output int bcnt);
    bit seen;
    seen = 1'b0;
    cyc  = 0;
    bcnt = 0;
    while (!seen && cyc < 40) begin
      @(negedge clk);
      cyc++;
      if (done === 1'b1) seen = 1'b1;
      else if (busy === 1'b1) bcnt++;
    end
    if (!seen) check("done_timeout", 64'd0, 64'd1);
  endtask

  task automatic run_mult(input logic [31:0] a, input logic [31:0] b,
                          input logic [31:0] eh, input logic [31:0] el, input string tag);
    int cyc;
    int bcnt;
    @(negedge clk);
    src_a = a;
    src_b = b;
    start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
    wait_done(cyc, bcnt);
    check({tag, "_lat"}, 64'(cyc), 64'd33);
    check({tag, "_busycyc"}, 64'(bcnt), 64'd32);
    check({tag, "_hi"}, 64'(hi), 64'(eh));
    check({tag, "_lo"}, 64'(lo), 64'(el));
    check({tag, "_busy_done"}, 64'(busy), 64'd0);
    @(negedge clk);
    check({tag, "_done_once"}, 64'(done), 64'd0);
  endtask

  initial begin
    int bad;
    int cyc;
    int bcnt;
    rst   = 1'b1;
    start = 1'b0;
    src_a = '0;
    src_b = '0;
    rd_hi = 1'b0;
    rd_lo = 1'b0;

    // Reset state
    #2 rd_lo = 1'b1;
    #1 check("rst_rdlo", 64'(rd_data), 64'd0);
    rd_hi = 1'b1;
    #1;
    check("rst_rdhi", 64'(rd_data), 64'd0);
    check("rst_hi", 64'(hi), 64'd0);
    check("rst_lo", 64'(lo), 64'd0);
    check("rst_busy", 64'(busy), 64'd0);
    check("rst_stall", 64'(stall), 64'd0);
    check("rst_done", 64'(done), 64'd0);
    @(negedge clk);
    rst   = 1'b0;
    rd_hi = 1'b0;
    rd_lo = 1'b0;

    run_mult(32'd7, 32'd6, 32'h0, 32'h2A, "m7x6");
    run_mult(32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 32'h1, "mff");

    // Read-port priority
    rd_hi = 1'b1;
    rd_lo = 1'b1;
    #1 check("prio_both", 64'(rd_data), 64'hFFFF_FFFE);
    rd_hi = 1'b0;
    #1 check("prio_lo", 64'(rd_data), 64'h1);
    rd_lo = 1'b0;
    #1 check("prio_none", 64'(rd_data), 64'h1);

    // Abort with reset at RUN cycle 10
    @(negedge clk);
    src_a = 32'd100;
    src_b = 32'd100;
    start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
    repeat (10) @(negedge clk);
    check("abort_busy_pre", 64'(busy), 64'd1);
    rst = 1'b1;
    #1;
    check("abort_busy", 64'(busy), 64'd0);
    check("abort_hi", 64'(hi), 64'd0);
    check("abort_lo", 64'(lo), 64'd0);
    check("abort_done", 64'(done), 64'd0);
    @(negedge clk);
    rst = 1'b0;
    bad = 0;
    repeat (40) begin
      @(negedge clk);
      if (done !== 1'b0 || busy !== 1'b0) bad++;
    end
    check("abort_quiet", 64'(bad), 64'd0);
    run_mult(32'd2, 32'd3, 32'h0, 32'h6, "m2x3");

    run_mult(32'h8000_0000, 32'd2, 32'h1, 32'h0, "m80x2");

    // LO preload 42, then 3x5 with MFLO held in EX throughout
    run_mult(32'd21, 32'd2, 32'h0, 32'd42, "pre42");
    rd_lo = 1'b1;
    src_a = 32'd3;
    src_b = 32'd5;
    start = 1'b1;
    #1;
    check("hold_idle_stall", 64'(stall), 64'd0);
    @(posedge clk);
    #1 start = 1'b0;
    bad = 0;
    for (int i = 0; i < 32; i++) begin
      @(negedge clk);
      if (stall !== 1'b1 || rd_data !== 32'd42) bad++;
    end
    check("hold_run_stall_data", 64'(bad), 64'd0);
    @(negedge clk);
    check("hold_done", 64'(done), 64'd1);
    check("hold_done_stall", 64'(stall), 64'd0);
    check("hold_done_data", 64'(rd_data), 64'd15);
    rd_lo = 1'b0;

    // Second MULTU held high across RUN, accepted in the done cycle
    @(negedge clk);
    src_a = 32'd9;
    src_b = 32'd11;
    start = 1'b1;
    @(posedge clk);
    #1;
    src_a = 32'd4;
    src_b = 32'd5;
    bad = 0;
    for (int i = 0; i < 32; i++) begin
      @(negedge clk);
      if (stall !== 1'b1 || busy !== 1'b1) bad++;
    end
    check("b2b_run_stall", 64'(bad), 64'd0);
    @(negedge clk);
    check("b2b_done", 64'(done), 64'd1);
    check("b2b_done_busy", 64'(busy), 64'd0);
    check("b2b_done_stall", 64'(stall), 64'd0);
    check("b2b_lo1", 64'(lo), 64'd99);
    @(posedge clk);
    #1 start = 1'b0;
    check("b2b_busy2", 64'(busy), 64'd1);
    check("b2b_done2_low", 64'(done), 64'd0);
    check("b2b_lo_hold", 64'(lo), 64'd99);
    wait_done(cyc, bcnt);
    check("b2b_lat2", 64'(cyc), 64'd33);
    check("b2b_lo2", 64'(lo), 64'd20);
    check("b2b_hi2", 64'(hi), 64'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/multu_hilo_unit.md
# multu_hilo_unit

Multi-cycle unsigned 32×32 shift-add multiplier with architectural HI/LO registers for the MIPS pipeline's execute stage. It sits beside the ALU in EX and is consumed by the pipeline control. The EX stage issues MULTU operands, and later MFHI/MFLO read the results. While a multiply is in flight, a stall request holds the pipeline only when a dependent HI/LO access or a second MULTU reaches EX.

## Interface
Parameters:
- WIDTH, 32, operand width; HI and LO are each WIDTH bits.

Ports:
- clk  input  1  system clock; all state updates on the rising edge.
- rst  input  1  asynchronous, active-high reset.
- start  input  1  MULTU in EX this cycle; level, sampled each rising edge.
- src_a  input  WIDTH  multiplicand (rs value).
- src_b  input  WIDTH  multiplier (rt value).
- rd_hi  input  1  MFHI in EX this cycle.
- rd_lo  input  1  MFLO in EX this cycle.
- rd_data  output  WIDTH  HI if rd_hi, else LO; combinational.
- busy  output  1  multiply in progress.
- stall  output  1  pipeline hold request.
- done  output  1  one-cycle pulse: HI/LO were just written.
- hi  output  WIDTH  current HI register.
- lo  output  WIDTH  current LO register.

## Operation
- States:
  - IDLE: busy=0.
  - RUN: busy=1.
- Internal registers:
  - mcand (WIDTH).
  - acc (2*WIDTH+1, bit 2*WIDTH is the carry).
  - count (log2(WIDTH)+1 bits).
- IDLE, start=1 at an edge: mcand<=src_a, acc<={0, src_b}, count<=0, go to RUN.
- IDLE, start=0: remain in IDLE; no register changes.
- RUN, each edge:
  - If acc[0]=1, the upper WIDTH+1 bits become acc[2W-1:W] + mcand, with the carry kept.
  - The whole acc shifts right by 1; count increments.
- RUN, edge where count reaches WIDTH-1 (the WIDTH-th iteration):
  - HI<=final product[2W-1:W], LO<=final product[W-1:0] on that same edge.
  - Go to IDLE; done<=1 for the next cycle only.
- HI/LO keep their previous values during RUN; only a completed multiply updates them.
- rd_data: rd_hi has priority over rd_lo. With neither asserted, rd_data shows LO.
- stall = busy & (start | rd_hi | rd_lo).
  - A start seen during RUN is ignored by the FSM.
  - The pipeline holds that start; the unit accepts it on the first edge in IDLE.
- Arithmetic is unsigned only. The product is exact across the full 2*WIDTH bits, with no overflow flag.

## Timing
- Reset (async, immediate):
  - state=IDLE, busy=0, done=0, stall=0.
  - hi=0, lo=0, rd_data=0.
  - mcand, acc and count cleared.
- Reset asserted mid-RUN: the multiply is aborted. HI/LO become 0, no done pulse follows, and the first start after reset release is accepted.
- Latency:
  - start sampled at edge E0; busy=1 from E0 through edge E0+WIDTH.
  - HI/LO are written at edge E0+WIDTH (E0+32 for the default).
  - done=1 and busy=0 during the cycle after E0+WIDTH.
- The done cycle is IDLE. A start in that cycle is accepted, giving back-to-back throughput of WIDTH+1 cycles per multiply.
- MFHI/MFLO in the done cycle returns the new product with stall=0.
- rd_data and stall are combinational from registers and inputs: no clock delay.

## Test plan
- Reset, then rd_lo=1 and rd_hi=1 -> rd_data=0, hi=lo=0, busy=0, stall=0, done=0.
- start with src_a=7, src_b=6 -> busy for 32 cycles, done pulses exactly once in cycle 33, HI=0x00000000, LO=0x0000002A.
- start with src_a=0xFFFFFFFF, src_b=0xFFFFFFFF -> HI=0xFFFFFFFE, LO=0x00000001. Then 0x80000000×2 -> HI=0x00000001, LO=0x00000000, which checks carry and the high half.
- Preload LO=42 from an earlier multiply, start 3×5, hold rd_lo=1 throughout:
  - stall=1 in every RUN cycle, with rd_data=42 during RUN.
  - Done cycle: stall=0, rd_data=15.
- Second start held high across RUN -> it is ignored until the done cycle, then accepted there. busy rises on the next edge, and the second product appears 33 cycles later.
- Assert rst for one cycle at RUN cycle 10 -> busy=0 and hi=lo=0 immediately, no done pulse. A later 2×3 multiply gives LO=6.
